// File: rtl/fsram_pkg.sv
// Shared definitions for the banked dual-port scratch RAM: clear-FSM states,
// the collision counter width and default geometry.
package fsram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

    localparam int unsigned COLL_CNT_W   = 16;
    localparam int unsigned BANK_NUM_DEF = 8;
    localparam int unsigned ADDR_W_DEF   = 11;
    localparam int unsigned DATA_W_DEF   = 16;

endpackage

// File: rtl/fsram_dp_mem.sv
// Behavioural single-clock two-port RAM with registered read data.
// Same-address write arbitration and read bypass are handled by the caller.
module fsram_dp_mem
    import fsram_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_a_en,
    input  logic              i_a_we,
    input  logic [ADDR_W-1:0] i_a_addr,
    input  logic [DATA_W-1:0] i_a_wdata,
    output logic [DATA_W-1:0] o_a_rdata,
    input  logic              i_b_en,
    input  logic              i_b_we,
    input  logic [ADDR_W-1:0] i_b_addr,
    input  logic [DATA_W-1:0] i_b_wdata,
    output logic [DATA_W-1:0] o_b_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (i_b_en && i_b_we) r_mem[i_b_addr] <= i_b_wdata;
        if (i_a_en && i_a_we) r_mem[i_a_addr] <= i_a_wdata;
    end

    // Read registers hold their value when no read is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_a_rdata <= '0;
            o_b_rdata <= '0;
        end else begin
            if (i_a_en && !i_a_we) o_a_rdata <= r_mem[i_a_addr];
            if (i_b_en && !i_b_we) o_b_rdata <= r_mem[i_b_addr];
        end
    end

endmodule

// File: rtl/fsram_pbank.sv
// BANK_NUM independent dual-port banks with write-collision counting and a
// zero-fill clear engine. Define FSRAM_BYPASS_EN for same-cycle write-to-read bypass.
module fsram_pbank
    import fsram_pkg::*;
#(
    parameter int unsigned BANK_NUM = BANK_NUM_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [BANK_NUM-1:0]          a_req,
    input  logic [BANK_NUM-1:0]          a_we,
    input  logic [BANK_NUM*ADDR_W-1:0]   a_addr,
    input  logic [BANK_NUM*DATA_W-1:0]   a_wdata,
    output logic [BANK_NUM*DATA_W-1:0]   a_rdata,
    output logic [BANK_NUM-1:0]          a_rvalid,
    input  logic [BANK_NUM-1:0]          b_req,
    input  logic [BANK_NUM-1:0]          b_we,
    input  logic [BANK_NUM*ADDR_W-1:0]   b_addr,
    input  logic [BANK_NUM*DATA_W-1:0]   b_wdata,
    output logic [BANK_NUM*DATA_W-1:0]   b_rdata,
    output logic [BANK_NUM-1:0]          b_rvalid,
    input  logic                         clr_start,
    output logic                         clr_busy,
    output logic                         clr_done,
    output logic [COLL_CNT_W-1:0]        coll_cnt
);

    clr_state_t          r_state;
    logic [ADDR_W-1:0]   r_cnt;
    logic                r_busy;
    logic                r_done;
    logic [COLL_CNT_W-1:0] r_coll_cnt;
    logic [BANK_NUM-1:0] r_a_rvalid, r_b_rvalid;

    logic                w_clearing;
    logic [BANK_NUM-1:0] w_a_rd, w_a_wr, w_b_rd, w_b_wr, w_coll;
    logic [COLL_CNT_W:0] w_coll_sum;

    assign w_clearing = (r_state == CLEAR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (clr_start) begin
                    r_state <= CLEAR;
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                end
                CLEAR: begin
                    r_cnt <= r_cnt + ADDR_W'(1);
                    if (r_cnt == '1) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Several banks may collide in the same cycle; each one counts.
    always_comb begin
        w_coll_sum = {1'b0, r_coll_cnt};
        for (int unsigned i = 0; i < BANK_NUM; i++) begin
            w_coll_sum = w_coll_sum + (COLL_CNT_W+1)'(w_coll[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_coll_cnt <= '0;
            r_a_rvalid <= '0;
            r_b_rvalid <= '0;
        end else begin
            r_coll_cnt <= w_coll_sum[COLL_CNT_W] ? '1 : w_coll_sum[COLL_CNT_W-1:0];
            r_a_rvalid <= w_a_rd;
            r_b_rvalid <= w_b_rd;
        end
    end

    for (genvar g = 0; g < BANK_NUM; g++) begin : g_bank
        logic [ADDR_W-1:0] w_a_addr, w_b_addr, w_a_mem_addr;
        logic [DATA_W-1:0] w_a_wdata, w_b_wdata, w_a_mem_wdata;
        logic [DATA_W-1:0] w_a_mem_rdata, w_b_mem_rdata;

        assign w_a_addr  = a_addr[(g+1)*ADDR_W-1 -: ADDR_W];
        assign w_b_addr  = b_addr[(g+1)*ADDR_W-1 -: ADDR_W];
        assign w_a_wdata = a_wdata[(g+1)*DATA_W-1 -: DATA_W];
        assign w_b_wdata = b_wdata[(g+1)*DATA_W-1 -: DATA_W];

        assign w_a_rd[g] = a_req[g] & ~a_we[g] & ~r_busy;
        assign w_a_wr[g] = a_req[g] &  a_we[g] & ~r_busy;
        assign w_b_rd[g] = b_req[g] & ~b_we[g] & ~r_busy;
        assign w_coll[g] = w_a_wr[g] & b_req[g] & b_we[g] & ~r_busy & (w_a_addr == w_b_addr);
        assign w_b_wr[g] = b_req[g] & b_we[g] & ~r_busy & ~w_coll[g];

        // Port A is borrowed by the clear engine; user requests are blocked meanwhile.
        assign w_a_mem_addr  = w_clearing ? r_cnt : w_a_addr;
        assign w_a_mem_wdata = w_clearing ? '0    : w_a_wdata;

        fsram_dp_mem #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W)
        ) u_mem (
            .clk       (clk),
            .rst       (rst),
            .i_a_en    (w_clearing | w_a_rd[g] | w_a_wr[g]),
            .i_a_we    (w_clearing | w_a_wr[g]),
            .i_a_addr  (w_a_mem_addr),
            .i_a_wdata (w_a_mem_wdata),
            .o_a_rdata (w_a_mem_rdata),
            .i_b_en    (w_b_rd[g] | w_b_wr[g]),
            .i_b_we    (w_b_wr[g]),
            .i_b_addr  (w_b_addr),
            .i_b_wdata (w_b_wdata),
            .o_b_rdata (w_b_mem_rdata)
        );

`ifdef FSRAM_BYPASS_EN
        logic              r_a_byp, r_b_byp;
        logic [DATA_W-1:0] r_a_byp_d, r_b_byp_d;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_a_byp   <= 1'b0;
                r_b_byp   <= 1'b0;
                r_a_byp_d <= '0;
                r_b_byp_d <= '0;
            end else begin
                if (w_a_rd[g]) begin
                    r_a_byp   <= w_b_wr[g] && (w_b_addr == w_a_addr);
                    r_a_byp_d <= w_b_wdata;
                end
                if (w_b_rd[g]) begin
                    r_b_byp   <= w_a_wr[g] && (w_a_addr == w_b_addr);
                    r_b_byp_d <= w_a_wdata;
                end
            end
        end

        assign a_rdata[(g+1)*DATA_W-1 -: DATA_W] = r_a_byp ? r_a_byp_d : w_a_mem_rdata;
        assign b_rdata[(g+1)*DATA_W-1 -: DATA_W] = r_b_byp ? r_b_byp_d : w_b_mem_rdata;
`else
        assign a_rdata[(g+1)*DATA_W-1 -: DATA_W] = w_a_mem_rdata;
        assign b_rdata[(g+1)*DATA_W-1 -: DATA_W] = w_b_mem_rdata;
`endif
    end

    assign a_rvalid = r_a_rvalid;
    assign b_rvalid = r_b_rvalid;
    assign clr_busy = r_busy;
    assign clr_done = r_done;
    assign coll_cnt = r_coll_cnt;

endmodule

// File: tb/tb_fsram_pbank.sv
// Directed bench for fsram_pbank: access timing, collisions, bypass, clear and reset.
module tb_fsram_pbank;

    localparam int BN = 8;
    localparam int AW = 11;
    localparam int DW = 16;

    logic              clk;
    logic              rst;
    logic [BN-1:0]     a_req, a_we, b_req, b_we;
    logic [BN*AW-1:0]  a_addr, b_addr;
    logic [BN*DW-1:0]  a_wdata, b_wdata;
    logic [BN*DW-1:0]  a_rdata, b_rdata;
    logic [BN-1:0]     a_rvalid, b_rvalid;
    logic              clr_start, clr_busy, clr_done;
    logic [15:0]       coll_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    fsram_pbank #(
        .BANK_NUM (BN),
        .ADDR_W   (AW),
        .DATA_W   (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_rdata   (a_rdata),
        .a_rvalid  (a_rvalid),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_rdata   (b_rdata),
        .b_rvalid  (b_rvalid),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .coll_cnt  (coll_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_req = '0; a_we = '0; b_req = '0; b_we = '0; clr_start = 1'b0;
    endtask

    task automatic set_a(input int b, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] d);
        a_req[b] = 1'b1;
        a_we[b]  = we;
        a_addr[b*AW +: AW]  = ad;
        a_wdata[b*DW +: DW] = d;
    endtask

    task automatic set_b(input int b, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] d);
        b_req[b] = 1'b1;
        b_we[b]  = we;
        b_addr[b*AW +: AW]  = ad;
        b_wdata[b*DW +: DW] = d;
    endtask

    function automatic logic [DW-1:0] sl(input logic [BN*DW-1:0] v, input int b);
        return v[b*DW +: DW];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        int busy_cyc, done_cyc, rv_seen, guard, bad;
        logic [DW-1:0] byp_exp;

        rst = 1'b1;
        idle();
        a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_rvalid", 32'(a_rvalid), 0);
        chk("rst_b_rvalid", 32'(b_rvalid), 0);
        chk("rst_a_rdata0", 32'(a_rdata === '0), 1);
        chk("rst_b_rdata0", 32'(b_rdata === '0), 1);
        chk("rst_coll", 32'(coll_cnt), 0);
        chk("rst_busy", 32'(clr_busy), 0);
        chk("rst_done", 32'(clr_done), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Write then read on the other port
        set_a(3, 1'b1, 11'h005, 16'hBEEF);
        tick();
        chk("wr_no_rvalid", 32'(a_rvalid), 0);
        idle();
        set_b(3, 1'b0, 11'h005, 16'h0000);
        tick();
        chk("rd_b_rvalid", 32'(b_rvalid), 32'h08);
        chk("rd_b_data", 32'(sl(b_rdata, 3)), 32'hBEEF);
        idle();
        tick();
        chk("hold_rvalid", 32'(b_rvalid), 0);
        chk("hold_data", 32'(sl(b_rdata, 3)), 32'hBEEF);

        // Write-write collision: A wins
        set_a(0, 1'b1, 11'h7FF, 16'h1111);
        set_b(0, 1'b1, 11'h7FF, 16'h2222);
        tick();
        chk("coll_cnt1", 32'(coll_cnt), 1);
        idle();
        set_a(0, 1'b0, 11'h7FF, 16'h0000);
        tick();
        chk("coll_data", 32'(sl(a_rdata, 0)), 32'h1111);
        chk("coll_rvalid", 32'(a_rvalid), 32'h01);

        // Two writes to different addresses of one bank both land
        idle();
        set_a(1, 1'b1, 11'h010, 16'h0A0A);
        set_b(1, 1'b1, 11'h011, 16'h0B0B);
        tick();
        idle();
        set_a(1, 1'b0, 11'h011, 16'h0000);
        set_b(1, 1'b0, 11'h010, 16'h0000);
        tick();
        chk("dual_a", 32'(sl(a_rdata, 1)), 32'h0B0B);
        chk("dual_b", 32'(sl(b_rdata, 1)), 32'h0A0A);
        chk("dual_nocoll", 32'(coll_cnt), 1);

        // Same-cycle write on A, read on B
        idle();
        set_b(2, 1'b1, 11'h020, 16'h0001);
        tick();
        idle();
        set_a(2, 1'b1, 11'h020, 16'h00AA);
        set_b(2, 1'b0, 11'h020, 16'h0000);
        tick();
`ifdef FSRAM_BYPASS_EN
        byp_exp = 16'h00AA;
`else
        byp_exp = 16'h0001;
`endif
        chk("byp_data", 32'(sl(b_rdata, 2)), 32'(byp_exp));
        chk("byp_rvalid", 32'(b_rvalid), 32'h04);
        idle();
        set_b(2, 1'b0, 11'h020, 16'h0000);
        tick();
        chk("byp_after", 32'(sl(b_rdata, 2)), 32'h00AA);

        // Fill every bank with ones, then clear
        for (int k = 0; k < 2048; k++) begin
            idle();
            for (int b = 0; b < BN; b++) set_a(b, 1'b1, AW'(k), 16'hFFFF);
            tick();
        end
        idle();
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int b = 0; b < BN; b++) set_a(b, 1'b0, AW'(b), 16'h0000);
        busy_cyc = 0; done_cyc = 0; rv_seen = 0; guard = 0;
        while (clr_busy === 1'b1 && guard < 3000) begin
            busy_cyc++;
            if (clr_done === 1'b1) done_cyc++;
            if (a_rvalid !== '0) rv_seen++;
            clr_start = (busy_cyc == 500);
            tick();
            guard++;
        end
        chk("clr_rv_exit", 32'(a_rvalid), 0);
        idle();
        chk("clr_timeout", 32'(guard < 3000), 1);
        chk("clr_busy_len", 32'(busy_cyc), 2049);
        chk("clr_done_cnt", 32'(done_cyc), 1);
        chk("clr_rv_busy", 32'(rv_seen), 0);
        chk("clr_done_low", 32'(clr_done), 0);
        bad = 0;
        for (int k = 0; k < 2048; k++) begin
            idle();
            for (int b = 0; b < BN; b++) begin
                set_a(b, 1'b0, AW'(k), 16'h0000);
                set_b(b, 1'b0, AW'(k), 16'h0000);
            end
            tick();
            if (a_rdata !== '0 || b_rdata !== '0 || a_rvalid !== '1 || b_rvalid !== '1) bad++;
        end
        idle();
        chk("clr_all_zero", 32'(bad), 0);
        chk("clr_keeps_coll", 32'(coll_cnt), 1);

        // Collision counter saturation over 70000 collisions
        set_a(0, 1'b1, 11'h7FF, 16'h1111);
        set_b(0, 1'b1, 11'h7FF, 16'h2222);
        for (int k = 0; k < 65533; k++) tick();
        chk("coll_fffe", 32'(coll_cnt), 32'hFFFE);
        tick();
        chk("coll_ffff", 32'(coll_cnt), 32'hFFFF);
        for (int k = 0; k < 4466; k++) tick();
        chk("coll_sat", 32'(coll_cnt), 32'hFFFF);
        idle();

        // Reset in the middle of a clear
        set_a(4, 1'b1, 11'h000, 16'h1234);
        set_b(4, 1'b1, 11'h1F4, 16'h1234);
        tick();
        idle();
        set_a(5, 1'b0, 11'h000, 16'h0000);
        tick();
        chk("pre_rv", 32'(a_rvalid), 32'h20);
        idle();
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int k = 0; k < 100; k++) tick();
        chk("mid_busy", 32'(clr_busy), 1);
        rst = 1'b1;
        #1;
        chk("mrst_busy", 32'(clr_busy), 0);
        chk("mrst_coll", 32'(coll_cnt), 0);
        chk("mrst_rv", 32'({a_rvalid, b_rvalid}), 0);
        chk("mrst_rdata0", 32'(a_rdata === '0 && b_rdata === '0), 1);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("mrst_idle", 32'(clr_busy), 0);
        set_a(4, 1'b0, 11'h000, 16'h0000);
        set_b(4, 1'b0, 11'h1F4, 16'h0000);
        tick();
        chk("part_cleared", 32'(sl(a_rdata, 4)), 0);
        chk("part_kept", 32'(sl(b_rdata, 4)), 32'h1234);
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fsram_pbank.md
FSRAM_PBANK -- requirements
Module: fsram_pbank

Interface
REQ-001 SHALL have parameter BANK_NUM, default 8: number of independent dual-port banks.
REQ-002 SHALL have parameter ADDR_W, default 11: per-bank address width; depth is 2**ADDR_W words.
REQ-003 SHALL have parameter DATA_W, default 16: word width.
REQ-004 SHALL have ports clk (in, 1), the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst (in, 1), the asynchronous, active-high reset.
REQ-006 SHALL have ports a_req, a_we, b_req and b_we (in, BANK_NUM each): per-bank access request and write enable for ports A and B.
REQ-007 SHALL have ports a_addr and b_addr (in, BANK_NUM*ADDR_W each) and a_wdata and b_wdata (in, BANK_NUM*DATA_W each); bank i occupies slice [(i+1)*W-1 -: W].
REQ-008 SHALL have ports a_rdata and b_rdata (out, BANK_NUM*DATA_W each) and a_rvalid and b_rvalid (out, BANK_NUM each).
REQ-009 SHALL have port clr_start (in, 1): pulse that starts zero-fill of all banks.
REQ-010 SHALL have ports clr_busy (out, 1) and clr_done (out, 1, one-cycle pulse).
REQ-011 SHALL have port coll_cnt (out, 16): saturating count of write-write collisions.

Function
REQ-012 SHALL accept a read on port P, bank i, when P_req[i]=1 and P_we[i]=0; P_rdata slice i then holds the addressed word and P_rvalid[i]=1 exactly one cycle later.
REQ-013 SHALL commit a write on port P, bank i, when P_req[i]=1 and P_we[i]=1; the write produces no rvalid.
REQ-014 SHALL hold P_rdata slice i at its last value, with P_rvalid[i]=0, in any cycle following no accepted read.
REQ-015 SHALL, when A and B both write the same bank and address in one cycle, store A's data, drop B's write, and increment coll_cnt, saturating at 16'hFFFF.
REQ-016 SHALL make a read after a write to the same bank and address, in any later cycle, return the written data.
REQ-017 SHALL run a clear FSM with states IDLE, CLEAR and DONE.
  - IDLE to CLEAR on clr_start.
  - CLEAR writes zero to address cnt in every bank simultaneously, with cnt running from 0 to 2**ADDR_W-1.
  - CLEAR to DONE when cnt wraps; DONE to IDLE after one cycle.
REQ-018 SHALL hold clr_busy=1 in CLEAR and DONE, and assert clr_done=1 only in DONE.
REQ-019 SHALL ignore clr_start unless the FSM is in IDLE.
REQ-020 SHALL ignore all port requests while clr_busy=1: no writes, no rvalid.

Reset
REQ-021 SHALL, on rst, force the following and leave the memory array contents undefined:
  - a_rvalid and b_rvalid = 0;
  - a_rdata and b_rdata = 0;
  - coll_cnt = 0;
  - FSM = IDLE, cnt = 0;
  - clr_busy = 0, clr_done = 0.
REQ-022 SHALL abort a clear in progress on rst; after release, memory is partially cleared and the FSM is in IDLE.

Configuration
REQ-023 SHALL, with macro FSRAM_BYPASS_EN defined, return the newly written data for a same-cycle read on one port and write on the other port to the same bank and address.
REQ-024 SHALL, without FSRAM_BYPASS_EN, return the old word in that case (read-before-write).

Structure
REQ-025 SHALL place FSM state encoding, the COLL_CNT_W=16 constant and the default parameter values in shared package fsram_pkg.
REQ-026 SHALL instantiate BANK_NUM copies of sub-module fsram_dp_mem, a behavioural single-clock two-port RAM with registered read, ADDR_W x DATA_W; bypass and collision muxing sit outside it.

Verification
REQ-027 SHALL cover write then read: A writes bank 3, addr 0x005, 0xBEEF at cycle t; B reads the same location at t+1 -> b_rvalid[3]=1 and b_rdata slice 3 = 0xBEEF at t+2.
REQ-028 SHALL cover write-write collision: A writes 0x1111 and B writes 0x2222 to bank 0, addr 0x7FF, same cycle -> the location reads 0x1111 and coll_cnt = 1; repeat 70000 times -> coll_cnt = 0xFFFF.
REQ-029 SHALL cover same-cycle bypass: location holds 0x0001; A writes 0x00AA and B reads the same location in one cycle -> B sees 0x00AA with FSRAM_BYPASS_EN, 0x0001 without.
REQ-030 SHALL cover clear: fill all banks with 0xFFFF, pulse clr_start -> clr_busy high for 2049 cycles, clr_done pulses once, every location reads 0.
REQ-031 SHALL cover requests during clear: A read requests while clr_busy=1 -> a_rvalid stays 0; a second clr_start while busy -> no restart.
REQ-032 SHALL cover reset mid-clear: assert rst at cnt=100 -> clr_busy=0, all rvalid=0, coll_cnt=0 immediately; FSM returns to IDLE.
